seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
//
// PURPOSE
//  Time-multiplexed scan controller for the board's N-digit common-anode 7-segment display.
//  Owns a prescaler, gives each digit a fixed slot (BLANK, then DRIVE) and decodes hex nibbles to segments.
//  Sits between result registers (adder outputs) and the display pins.
//  Replaces free-running divided clocks: all logic runs on CLK_in, with no derived clocks.
//
// PARAMETERS
//  N_DIGITS   8       digits scanned, 2..8
//  DIV        100000  CLK_in cycles per digit slot, >= 2
//  BLANK_CYC  1000    leading cycles of each slot with all anodes off (anti-ghosting), 0 <= BLANK_CYC < DIV
//
// PORTS
//  CLK_in      in   1           system clock; sole clock
//  rst         in   1           reset; synchronous, active-high
//  en          in   1           1 = scan, 0 = display dark (IDLE)
//  digits      in   4*N_DIGITS  hex nibbles; [3:0] = digit 0 (rightmost)
//  dig_mask    in   N_DIGITS    1 = digit may light; 0 = digit always dark (slot still consumed)
//  an          out  N_DIGITS    anode selects, active-low, at most one low
//  seg         out  7           {g,f,e,d,c,b,a}, active-low
//  scan_idx    out  clog2(N)    digit slot currently being scanned
//  frame_done  out  1           1-cycle pulse when a full N-digit frame completes
//
// BEHAVIOUR
//  - Reset, sampled on the CLK_in edge with rst=1: state=IDLE, cnt=0, scan_idx=0, an=all 1, seg=7'h7F, frame_done=0, snapshot=0.
//  - All outputs are registered. rst has priority over en.
//  - FSM states: IDLE, BLANK, DRIVE.
//  - IDLE: an=all 1, seg=7'h7F, and cnt holds 0.
//  - IDLE->BLANK: on the first cycle with en=1. Sets cnt=0, scan_idx=0 and snapshot<=digits.
//  - Slot counter: cnt runs 0..DIV-1 with width clog2(DIV). At DIV-1 it wraps to 0 and the slot ends.
//  - BLANK (cnt < BLANK_CYC): an=all 1, seg=7'h7F.
//    - Goes to DRIVE when cnt reaches BLANK_CYC.
//    - If BLANK_CYC=0, BLANK is skipped entirely.
//  - DRIVE (BLANK_CYC <= cnt <= DIV-1):
//    - an[scan_idx]=~dig_mask[scan_idx]; all other anodes stay 1.
//    - seg=hex7(snapshot[scan_idx]).
//  - Slot end: scan_idx<=scan_idx+1 and the FSM returns to BLANK.
//  - Frame wrap at scan_idx==N_DIGITS-1: scan_idx<=0, snapshot<=digits, and frame_done=1 for exactly that one cycle.
//  - Anti-tearing: digits is only sampled into snapshot at frame start. Mid-frame changes of digits are invisible.
//  - dig_mask is sampled live, not snapshotted.
//  - en=0 in any state: next cycle is IDLE with outputs dark and cnt/scan_idx reset to 0. No frame_done pulse.
//  - Re-asserting en restarts from digit 0 in BLANK.
//  - hex7 decode (active-low):
//    - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
//    - 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex)
//
// CONFIGURATION
//  SEG_SCAN_LZB_EN defined: leading-zero blanking.
//   - Per frame, from the snapshot: a digit i >= 1 is suppressed when it and every digit above it are 0.
//   - A suppressed digit drives an=all 1 in its DRIVE phase; slot timing is unchanged.
//   - Digit 0 is never suppressed.
//  Not defined: no suppression; every masked-in digit shows, including zeros.
//
// TESTING  (N_DIGITS=4, DIV=10, BLANK_CYC=2 unless noted)
//  1. Reset: rst=1 for 2 cycles, en=1 -> an=4'b1111, seg=7'h7F, scan_idx=0, frame_done=0; these hold during rst.
//  2. Normal scan: en=1, digits=16'h1234, mask=4'hF.
//     - Cycles 0-1 after entry: dark.
//     - Cycles 2-9: an=4'b1110, seg=7'h19.
//     - Slot 1: an=4'b1101, seg=7'h30.
//     - frame_done high exactly at cycle 40, then every 40 cycles.
//  3. Tearing: digits 16'h1234->16'hABCD at cycle 15 -> slots 2,3 still show 2 and 1. From cycle 40, slot 0 shows D (seg=7'h21).
//  4. en drop: en=0 at cycle 25 (DRIVE) -> cycle 26 an=4'b1111, scan_idx=0. en=1 again -> 2 dark cycles, then digit 0.
//  5. Mask: dig_mask=4'b0101 -> an never low for idx 1 or 3; frame_done period still 40.
//  6. SEG_SCAN_LZB_EN:
//     - digits=16'h0050 -> idx 3,2 dark; idx1 seg=7'h12; idx0 seg=7'h40.
//     - digits=16'h0000 -> only idx0 lights.
//     - Without the macro, all four digits light.

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: bundle between the result registers, the scan controller and the display pins
interface seg_scan_ctrl_if #(
    parameter int N_DIGITS = 8
);
    localparam int IW = $clog2(N_DIGITS);
    logic                  en;
    logic [4*N_DIGITS-1:0] digits;
    logic [N_DIGITS-1:0]   dig_mask;
    logic [N_DIGITS-1:0]   an;
    logic [6:0]            seg;
    logic [IW-1:0]         scan_idx;
    logic                  frame_done;
    modport master (output en, digits, dig_mask, input an, seg, scan_idx, frame_done);
    modport slave  (input en, digits, dig_mask, output an, seg, scan_idx, frame_done);
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed common-anode 7-segment scanner on CLK_in; SEG_SCAN_LZB_EN enables leading-zero blanking
module seg_scan_ctrl #(
    parameter int N_DIGITS  = 8,
    parameter int DIV       = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic               CLK_in,
    input  logic               rst,
    seg_scan_ctrl_if.slave     bus
);
    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(N_DIGITS);
    localparam logic [CW-1:0] LAST     = CW'(DIV - 1);
    localparam logic [CW-1:0] BL       = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t                state, state_n, first_st;
    logic [CW-1:0]         cnt, cnt_n;
    logic [IW-1:0]         idx, idx_n;
    logic [4*N_DIGITS-1:0] snap, snap_n;
    logic                  fd_n, lit;
    logic [N_DIGITS-1:0]   sup, an_n;
    logic [6:0]            seg_n;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    // next state: slot counter, digit index and frame snapshot (taken only at frame start)
    always_comb begin
        first_st = (BLANK_CYC == 0) ? DRIVE : BLANK;
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        snap_n   = snap;
        fd_n     = 1'b0;
        if (!bus.en) begin
            state_n = IDLE;
            cnt_n   = '0;
            idx_n   = '0;
        end else if (state == IDLE) begin
            state_n = first_st;
            cnt_n   = '0;
            idx_n   = '0;
            snap_n  = bus.digits;
        end else if (cnt == LAST) begin
            state_n = first_st;
            cnt_n   = '0;
            idx_n   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
            snap_n  = (idx == IDX_LAST) ? bus.digits : snap;
            fd_n    = (idx == IDX_LAST);
        end else begin
            cnt_n   = cnt + 1'b1;
            state_n = (cnt_n == BL) ? DRIVE : state;
        end
    end

`ifdef SEG_SCAN_LZB_EN
    logic z;
    // a digit above 0 is suppressed when it and every higher digit of the snapshot are zero
    always_comb begin
        sup = '0;
        z   = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            z      = z & (snap_n[4*i +: 4] == 4'h0);
            sup[i] = z;
        end
    end
`else
    // no leading-zero blanking: every masked-in digit shows
    always_comb sup = '0;
`endif

    // pin values for the coming cycle; dig_mask is taken live, digit value from the snapshot
    always_comb begin
        lit   = (state_n == DRIVE) && bus.dig_mask[idx_n] && !sup[idx_n];
        an_n  = lit ? ~(N_DIGITS'(1) << idx_n) : '1;
        seg_n = (state_n == DRIVE) ? hex7(snap_n[{idx_n, 2'b00} +: 4]) : 7'h7F;
    end

    // state register and registered display outputs
    always_ff @(posedge CLK_in) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            idx            <= '0;
            snap           <= '0;
            bus.an         <= '1;
            bus.seg        <= 7'h7F;
            bus.frame_done <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            idx            <= idx_n;
            snap           <= snap_n;
            bus.an         <= an_n;
            bus.seg        <= seg_n;
            bus.frame_done <= fd_n;
        end
    end

    assign bus.scan_idx = idx;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed vectors for the 4-digit, DIV=10, BLANK_CYC=2 scanner
module tb_seg_scan_ctrl;
    logic CLK_in = 1'b0;
    logic rst    = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   tear_cyc = -1;
    logic [15:0] tear_val = '0;

    seg_scan_ctrl_if #(.N_DIGITS(4)) bus ();
    seg_scan_ctrl #(.N_DIGITS(4), .DIV(10), .BLANK_CYC(2)) dut (.CLK_in(CLK_in), .rst(rst), .bus(bus));

    always #5 CLK_in = ~CLK_in;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [6:0] seg;
        logic [1:0] idx;
        logic       fd;
    } vec_t;

    localparam int NV = 17;
    vec_t v[NV];

`ifdef SEG_SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK_in);
        #1;
        cyc++;
        if (cyc == tear_cyc) bus.digits = tear_val;
    endtask

    task automatic start(input logic [15:0] d, input logic [3:0] m);
        rst    = 1'b1;
        bus.en = 1'b0;
        step();
        rst          = 1'b0;
        bus.digits   = d;
        bus.dig_mask = m;
        bus.en       = 1'b1;
        step();
        cyc = 0;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic chk_out(input string name, input logic [3:0] an, input logic [6:0] seg);
        chk({name, "_an"}, int'(bus.an), int'(an));
        chk({name, "_seg"}, int'(bus.seg), int'(seg));
    endtask

    initial begin
        int pulses, bad;
        v[0]  = '{0,  4'hF, 7'h7F, 2'd0, 1'b0};
        v[1]  = '{1,  4'hF, 7'h7F, 2'd0, 1'b0};
        v[2]  = '{2,  4'hE, 7'h19, 2'd0, 1'b0};
        v[3]  = '{9,  4'hE, 7'h19, 2'd0, 1'b0};
        v[4]  = '{10, 4'hF, 7'h7F, 2'd1, 1'b0};
        v[5]  = '{12, 4'hD, 7'h30, 2'd1, 1'b0};
        v[6]  = '{19, 4'hD, 7'h30, 2'd1, 1'b0};
        v[7]  = '{22, 4'hB, 7'h24, 2'd2, 1'b0};
        v[8]  = '{32, 4'h7, 7'h79, 2'd3, 1'b0};
        v[9]  = '{39, 4'h7, 7'h79, 2'd3, 1'b0};
        v[10] = '{40, 4'hF, 7'h7F, 2'd0, 1'b1};
        v[11] = '{41, 4'hF, 7'h7F, 2'd0, 1'b0};
        v[12] = '{42, 4'hE, 7'h21, 2'd0, 1'b0};
        v[13] = '{52, 4'hD, 7'h46, 2'd1, 1'b0};
        v[14] = '{62, 4'hB, 7'h03, 2'd2, 1'b0};
        v[15] = '{72, 4'h7, 7'h08, 2'd3, 1'b0};
        v[16] = '{80, 4'hF, 7'h7F, 2'd0, 1'b1};

        bus.en       = 1'b1;
        bus.digits   = 16'h1234;
        bus.dig_mask = 4'hF;
        rst          = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            chk_out("reset", 4'hF, 7'h7F);
            chk("reset_idx", int'(bus.scan_idx), 0);
            chk("reset_fd", int'(bus.frame_done), 0);
        end

        tear_cyc = 15;
        tear_val = 16'hABCD;
        start(16'h1234, 4'hF);
        for (int k = 0; k < NV; k++) begin
            run_to(v[k].cyc);
            chk_out($sformatf("scan%0d", v[k].cyc), v[k].an, v[k].seg);
            chk($sformatf("scan%0d_idx", v[k].cyc), int'(bus.scan_idx), int'(v[k].idx));
            chk($sformatf("scan%0d_fd", v[k].cyc), int'(bus.frame_done), int'(v[k].fd));
        end
        tear_cyc = -1;

        start(16'h1234, 4'hF);
        run_to(25);
        chk_out("drop25", 4'hB, 7'h24);
        bus.en = 1'b0;
        step();
        chk_out("drop26", 4'hF, 7'h7F);
        chk("drop26_idx", int'(bus.scan_idx), 0);
        chk("drop26_fd", int'(bus.frame_done), 0);
        bus.en = 1'b1;
        step();
        chk_out("rearm0", 4'hF, 7'h7F);
        chk("rearm0_idx", int'(bus.scan_idx), 0);
        step();
        chk_out("rearm1", 4'hF, 7'h7F);
        step();
        chk_out("rearm2", 4'hE, 7'h19);

        start(16'h1234, 4'b0101);
        pulses = 0;
        bad    = 0;
        for (int c = 1; c <= 80; c++) begin
            step();
            if (bus.an[1] !== 1'b1 || bus.an[3] !== 1'b1) bad++;
            if (bus.frame_done === 1'b1) pulses++;
            if (cyc == 2) chk_out("mask2", 4'hE, 7'h19);
            if (cyc == 22) chk_out("mask22", 4'hB, 7'h24);
            if (cyc == 40) chk("mask_fd40", int'(bus.frame_done), 1);
        end
        chk("mask_dark13", bad, 0);
        chk("mask_pulses", pulses, 2);

        start(16'h0050, 4'hF);
        run_to(2);
        chk_out("lzb50_i0", 4'hE, 7'h40);
        run_to(12);
        chk_out("lzb50_i1", 4'hD, 7'h12);
        run_to(22);
        chk("lzb50_i2_an", int'(bus.an), LZB ? 'hF : 'hB);
        run_to(32);
        chk("lzb50_i3_an", int'(bus.an), LZB ? 'hF : 'h7);

        start(16'h0000, 4'hF);
        run_to(2);
        chk_out("lzb0_i0", 4'hE, 7'h40);
        run_to(12);
        chk("lzb0_i1_an", int'(bus.an), LZB ? 'hF : 'hD);
        run_to(22);
        chk("lzb0_i2_an", int'(bus.an), LZB ? 'hF : 'hB);
        run_to(32);
        chk("lzb0_i3_an", int'(bus.an), LZB ? 'hF : 'h7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
